seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the board's multi-digit seven-segment display. It shares one hex-to-segment decoder across `NDIG` digits by cycling digit selects with a programmable dwell and blanking interval. It accepts new display contents through a valid/ready handshake and commits them only at frame boundaries, so no frame ever mixes old and new digits. It sits between the encoder/display datapath blocks and the top-level `an`/`seg` pins.

## Interface
- `NDIG`, 8, number of digits (≥2)
- `SCAN_DIV`, 50000, clock cycles each digit is lit (≥1)
- `BLANK_CYC`, 4, all-dark cycles between digits, anti-ghosting (≥1)

- `clk` in 1: the single clock
- `rst` in 1: asynchronous, active-high reset
- `wr_valid` in 1: new frame data offered
- `wr_ready` out 1: controller can accept data
- `wr_data` in 4·NDIG: hex digits; digit i = `wr_data[4i+3:4i]`, digit NDIG-1 most significant
- `wr_mask` in NDIG: per-digit enable; 0 = digit dark
- `an` out NDIG: digit selects, active-low
- `seg` out 7: segments a–g (`seg[0]`=a), active-low
- `scan_idx` out clog2(NDIG): digit currently addressed
- `frame_done` out 1: one-cycle pulse at each frame commit point

## Operation
- Registers: `state`, `idx`, dwell counter `cnt`, display buffer `buf_d`/`buf_m`, pending buffer `pend_d`/`pend_m`, `pend_v`.
- Reset values: state OFF; `idx`, `cnt`, `buf_*`, `pend_*` = 0; `an` = all 1; `seg` = 7'h7F; `wr_ready` = 1; `frame_done` = 0.
- OFF state:
  - `an` = all 1; `seg` = 7'h7F; `wr_ready` = 1.
  - On accept (`wr_valid & wr_ready`): load data and mask directly into `buf_*`.
  - If the mask is nonzero, go to SHOW with `idx`=0, `cnt`=0. If the mask is 0, stay in OFF.
- SHOW state:
  - `an` = ~(1<<idx) if `buf_m[idx]`, else all 1.
  - `seg` = hex decode of `buf_d[idx]` (0–F, standard glyphs), forced to 7'h7F when the digit is dark.
  - `cnt` counts 0..SCAN_DIV-1. At SCAN_DIV-1: go to BLANK, `cnt`←0.
- BLANK state:
  - `an` all 1; `seg` 7'h7F.
  - `cnt` counts 0..BLANK_CYC-1. At BLANK_CYC-1: `idx`←(idx+1) mod NDIG, `cnt`←0.
  - If `idx` was NDIG-1 (frame end): pulse `frame_done`. If `pend_v`, also copy `pend_*` into `buf_*` and clear `pend_v`.
  - If the resulting `buf_m` is 0, go to OFF; otherwise go to SHOW.
- Handshake in SHOW/BLANK:
  - `wr_ready` = ~`pend_v`.
  - An accept loads `pend_*` and sets `pend_v`.
  - An accept on the same cycle as a frame end is held pending for the following frame; there is no bypass.
  - `wr_data`/`wr_mask` are ignored unless accepted.
- Outputs are combinational decode of registered state/`idx`/`buf_*`. There is no extra latency.

## Timing
- Digit period: SCAN_DIV+BLANK_CYC cycles. Frame period: NDIG·(SCAN_DIV+BLANK_CYC) cycles.
- Accept in OFF: first lit digit appears the cycle after the accept edge.
- Accept in SHOW/BLANK: visible at the first SHOW cycle after the next frame end. Worst case is one full frame plus one cycle.
- `frame_done` is high exactly during the last BLANK cycle of digit NDIG-1.
- Reset asserted mid-frame: all registers clear immediately and asynchronously, and any pending data is lost.

## Configuration
- `SEG_LZ_BLANK_EN` defined: leading-zero blanking.
  - An enabled digit i > 0 is dark if `buf_d[i]`=0 and every enabled digit above i is also 0.
  - Digit 0 is never suppressed by this rule.
  - Dwell timing is unchanged; suppressed digits still consume their slot.
- `SEG_LZ_BLANK_EN` not defined: every enabled digit is shown, zeros included.

## Structure
- Shared package `seg_pkg`:
  - glyph constants for 0–F;
  - `SEG_OFF` = 7'h7F;
  - state enum (OFF, SHOW, BLANK).
- One sub-module: `hex7seg`, a combinational 4-bit → 7-bit active-low decoder with enable, instantiated once.

## Test plan
Use NDIG=4, SCAN_DIV=3, BLANK_CYC=2, so the frame is 20 cycles.
- Reset → `an`=4'hF, `seg`=7'h7F, `wr_ready`=1. These hold indefinitely with no write.
- In OFF, write data 16'h4321 with mask 4'hF → next cycle `an`=4'hE, `seg`=glyph 1 for 3 cycles, then 2 dark cycles, then `an`=4'hD with glyph 2. `frame_done` pulses at cycle 20.
- Mid-frame write 16'hABCD → `wr_ready` drops. The old digits persist until `frame_done`, then D, C, B, A show. A second write offered during the wait is not accepted.
- Write mask 4'b0101 → `an` stays 4'hF in the slots for digits 1 and 3, and the slot timing is unchanged.
- Commit mask 0 at a frame end → state returns to OFF and outputs go dark.
- With `SEG_LZ_BLANK_EN`, data 16'h0050 mask 4'hF → digits 3 and 2 dark, digits 1 and 0 show 5 and 0. With data 16'h0000, only digit 0 shows 0.
- Assert `rst` during SHOW with a pending write → outputs go dark asynchronously. After release no pending data is committed and `wr_ready`=1.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller:
// active-low glyphs (seg[0] = a), the dark pattern and the scan FSM states.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    function automatic logic [6:0] hex_glyph(input logic [3:0] hex);
        logic [6:0] g;
        case (hex)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame-write handshake between the display datapath (master) and the
// scan controller (slave).
interface seg_scan_ctrl_if #(
    parameter int NDIG = 8
) ();
    logic                wr_valid;
    logic                wr_ready;
    logic [4*NDIG-1:0]   wr_data;
    logic [NDIG-1:0]     wr_mask;

    modport master (output wr_valid, output wr_data, output wr_mask, input wr_ready);
    modport slave  (input wr_valid, input wr_data, input wr_mask, output wr_ready);
endinterface

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Combinational hex to active-low seven-segment decoder with enable.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       en,
    output logic [6:0] seg
);

    // Disabled digits drive the all-dark pattern.
    always_comb seg = en ? hex_glyph(hex) : SEG_OFF;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller. New frames arrive via a
// valid/ready handshake and are committed only at frame boundaries.
// Optional feature: define SEG_LZ_BLANK_EN for leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG      = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    seg_scan_ctrl_if.slave            wr,
    output logic [NDIG-1:0]           an,
    output logic [6:0]                seg,
    output logic [$clog2(NDIG)-1:0]   scan_idx,
    output logic                      frame_done
);

    localparam int IDX_W   = $clog2(NDIG);
    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4*NDIG-1:0]   buf_d_q, buf_d_d;
    logic [NDIG-1:0]     buf_m_q, buf_m_d;
    logic [4*NDIG-1:0]   pend_d_q, pend_d_d;
    logic [NDIG-1:0]     pend_m_q, pend_m_d;
    logic                pend_v_q, pend_v_d;

    logic                accept;
    logic                frame_end;
    logic                digit_on;
    logic [3:0]          cur_hex;
    logic [NDIG-1:0]     lz_dark;

    // Handshake: always ready when idle, otherwise only with an empty pending slot.
    always_comb begin
        wr.wr_ready = (state_q == ST_OFF) ? 1'b1 : ~pend_v_q;
        accept      = wr.wr_valid & wr.wr_ready;
        frame_end   = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST) && (idx_q == IDX_LAST);
    end

    // Scan FSM, dwell counter and the display/pending buffers.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        buf_d_d  = buf_d_q;
        buf_m_d  = buf_m_q;
        pend_d_d = pend_d_q;
        pend_m_d = pend_m_q;
        pend_v_d = pend_v_q;
        case (state_q)
            ST_OFF: begin
                if (accept) begin
                    buf_d_d = wr.wr_data;
                    buf_m_d = wr.wr_mask;
                    idx_d   = '0;
                    cnt_d   = '0;
                    if (wr.wr_mask != '0) state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_BLANK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d = '0;
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    if (frame_end && pend_v_q) begin
                        buf_d_d  = pend_d_q;
                        buf_m_d  = pend_m_q;
                        pend_v_d = 1'b0;
                    end
                    state_d = (buf_m_d == '0) ? ST_OFF : ST_SHOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase
        // Accepting implies the slot was empty, so this never collides with the commit above.
        if (accept && (state_q != ST_OFF)) begin
            pend_d_d = wr.wr_data;
            pend_m_d = wr.wr_mask;
            pend_v_d = 1'b1;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    // Walk from the top digit down; a digit is dark while no enabled digit at or above it is nonzero.
    always_comb begin
        logic        all_zero;
        int unsigned i;
        all_zero = 1'b1;
        lz_dark  = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            i = NDIG - 1 - k;
            if (buf_m_q[i] && (buf_d_q[4*i +: 4] != 4'h0)) all_zero = 1'b0;
            lz_dark[i] = (i != 0) && all_zero;
        end
    end
`else
    // Every enabled digit is shown, zeros included.
    always_comb lz_dark = '0;
`endif

    // Output decode straight from registered state; no added latency.
    always_comb begin
        digit_on   = (state_q == ST_SHOW) && buf_m_q[idx_q] && !lz_dark[idx_q];
        cur_hex    = buf_d_q[{idx_q, 2'b00} +: 4];
        an         = digit_on ? ~(NDIG'(1) << idx_q) : '1;
        scan_idx   = idx_q;
        frame_done = frame_end;
    end

    hex7seg u_dec (
        .hex (cur_hex),
        .en  (digit_on),
        .seg (seg)
    );

    // State registers; reset clears everything including any pending frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_OFF;
            idx_q    <= '0;
            cnt_q    <= '0;
            buf_d_q  <= '0;
            buf_m_q  <= '0;
            pend_d_q <= '0;
            pend_m_q <= '0;
            pend_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            buf_d_q  <= buf_d_d;
            buf_m_q  <= buf_m_d;
            pend_d_q <= pend_d_d;
            pend_m_q <= pend_m_d;
            pend_v_q <= pend_v_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NDIG=4, SCAN_DIV=3, BLANK_CYC=2
// (20-cycle frame). Frame cycle c = 1..20: digit k lit at c = 5k+1..5k+3.
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] scan_idx;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl_if #(.NDIG(4)) wr_if ();

    seg_scan_ctrl #(.NDIG(4), .SCAN_DIV(3), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr_if),
        .an         (an),
        .seg        (seg),
        .scan_idx   (scan_idx),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic bit lit(input logic [15:0] d, input logic [3:0] m, input int k);
        bit allz;
        if (!m[k]) return 1'b0;
`ifdef SEG_LZ_BLANK_EN
        if (k > 0) begin
            allz = 1'b1;
            for (int j = k; j < 4; j++)
                if (m[j] && d[4*j +: 4] != 4'h0) allz = 1'b0;
            if (allz) return 1'b0;
        end
`else
        allz = 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [3:0] exp_an(input int c, input logic [15:0] d, input logic [3:0] m);
        int k = (c - 1) / 5;
        if (((c - 1) % 5) < 3 && lit(d, m, k)) return ~(4'b0001 << k);
        return 4'hF;
    endfunction

    function automatic logic [6:0] exp_seg(input int c, input logic [15:0] d, input logic [3:0] m);
        int k = (c - 1) / 5;
        if (((c - 1) % 5) < 3 && lit(d, m, k)) return glyph(d[4*k +: 4]);
        return 7'h7F;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || wr_if.wr_ready !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_held an=%h seg=%h rdy=%b fd=%b want an=f seg=7f rdy=1 fd=0", an, seg, wr_if.wr_ready, frame_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'hF || seg !== 7'h7F || wr_if.wr_ready !== 1'b1 || scan_idx !== 2'd0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle i=%0d an=%h seg=%h rdy=%b idx=%0d fd=%b want an=f seg=7f rdy=1 idx=0 fd=0",
                         i, an, seg, wr_if.wr_ready, scan_idx, frame_done);
            end
        end
    endtask

    task automatic test_off_write();
        @(negedge clk);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 16'h4321;
        wr_if.wr_mask  = 4'hF;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) wr_if.wr_valid = 1'b0;
            checks++;
            if (an !== exp_an(c, 16'h4321, 4'hF) || seg !== exp_seg(c, 16'h4321, 4'hF) ||
                frame_done !== (c == 20) || scan_idx !== 2'((c - 1) / 5)) begin
                errors++;
                $display("FAIL off_write c=%0d an=%h seg=%h fd=%b idx=%0d want an=%h seg=%h fd=%b idx=%0d", c, an, seg,
                         frame_done, scan_idx, exp_an(c, 16'h4321, 4'hF), exp_seg(c, 16'h4321, 4'hF), c == 20, (c - 1) / 5);
            end
        end
    endtask

    task automatic test_pending();
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an(c, 16'h4321, 4'hF) || seg !== exp_seg(c, 16'h4321, 4'hF) || frame_done !== (c == 20)) begin
                errors++;
                $display("FAIL pend_old c=%0d an=%h seg=%h fd=%b want an=%h seg=%h fd=%b", c, an, seg, frame_done,
                         exp_an(c, 16'h4321, 4'hF), exp_seg(c, 16'h4321, 4'hF), c == 20);
            end
            if (c == 7 || c == 8) begin
                checks++;
                if (wr_if.wr_ready !== (c == 7)) begin
                    errors++;
                    $display("FAIL pend_ready c=%0d rdy=%b want %b", c, wr_if.wr_ready, c == 7);
                end
            end
            if (c == 7) begin
                wr_if.wr_valid = 1'b1;
                wr_if.wr_data  = 16'hABCD;
                wr_if.wr_mask  = 4'hF;
            end
            if (c == 8) wr_if.wr_data = 16'h5555;
            if (c == 19) wr_if.wr_valid = 1'b0;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an(c, 16'hABCD, 4'hF) || seg !== exp_seg(c, 16'hABCD, 4'hF) || frame_done !== (c == 20)) begin
                errors++;
                $display("FAIL pend_new c=%0d an=%h seg=%h fd=%b want an=%h seg=%h fd=%b", c, an, seg, frame_done,
                         exp_an(c, 16'hABCD, 4'hF), exp_seg(c, 16'hABCD, 4'hF), c == 20);
            end
            if (c == 1) begin
                checks++;
                if (wr_if.wr_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL pend_ready_back rdy=%b want 1", wr_if.wr_ready);
                end
            end
            if (c == 20) begin
                // Offered on the frame-end cycle: must wait a whole extra frame.
                wr_if.wr_valid = 1'b1;
                wr_if.wr_data  = 16'h9876;
                wr_if.wr_mask  = 4'b0101;
            end
        end
    endtask

    task automatic test_mask();
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                wr_if.wr_valid = 1'b0;
                checks++;
                if (wr_if.wr_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL edge_accept_pending rdy=%b want 0", wr_if.wr_ready);
                end
            end
            checks++;
            if (an !== exp_an(c, 16'hABCD, 4'hF) || seg !== exp_seg(c, 16'hABCD, 4'hF) || frame_done !== (c == 20)) begin
                errors++;
                $display("FAIL no_bypass c=%0d an=%h seg=%h fd=%b want an=%h seg=%h fd=%b", c, an, seg, frame_done,
                         exp_an(c, 16'hABCD, 4'hF), exp_seg(c, 16'hABCD, 4'hF), c == 20);
            end
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an(c, 16'h9876, 4'b0101) || seg !== exp_seg(c, 16'h9876, 4'b0101) || frame_done !== (c == 20)) begin
                errors++;
                $display("FAIL mask c=%0d an=%h seg=%h fd=%b want an=%h seg=%h fd=%b", c, an, seg, frame_done,
                         exp_an(c, 16'h9876, 4'b0101), exp_seg(c, 16'h9876, 4'b0101), c == 20);
            end
            if (c == 3) begin
                wr_if.wr_valid = 1'b1;
                wr_if.wr_data  = 16'h1234;
                wr_if.wr_mask  = 4'h0;
            end
            if (c == 4) wr_if.wr_valid = 1'b0;
        end
    endtask

    task automatic test_commit_zero();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'hF || seg !== 7'h7F || wr_if.wr_ready !== 1'b1 || frame_done !== 1'b0 || scan_idx !== 2'd0) begin
                errors++;
                $display("FAIL commit_zero i=%0d an=%h seg=%h rdy=%b fd=%b idx=%0d want an=f seg=7f rdy=1 fd=0 idx=0",
                         i, an, seg, wr_if.wr_ready, frame_done, scan_idx);
            end
        end
    endtask

    task automatic test_lz();
        @(negedge clk);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 16'h0050;
        wr_if.wr_mask  = 4'hF;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) wr_if.wr_valid = 1'b0;
            checks++;
            if (an !== exp_an(c, 16'h0050, 4'hF) || seg !== exp_seg(c, 16'h0050, 4'hF)) begin
                errors++;
                $display("FAIL lz_0050 c=%0d an=%h seg=%h want an=%h seg=%h", c, an, seg,
                         exp_an(c, 16'h0050, 4'hF), exp_seg(c, 16'h0050, 4'hF));
            end
            if (c == 10) begin
                wr_if.wr_valid = 1'b1;
                wr_if.wr_data  = 16'h0000;
            end
            if (c == 11) wr_if.wr_valid = 1'b0;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an(c, 16'h0000, 4'hF) || seg !== exp_seg(c, 16'h0000, 4'hF)) begin
                errors++;
                $display("FAIL lz_0000 c=%0d an=%h seg=%h want an=%h seg=%h", c, an, seg,
                         exp_an(c, 16'h0000, 4'hF), exp_seg(c, 16'h0000, 4'hF));
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        @(negedge clk);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 16'hFFFF;
        wr_if.wr_mask  = 4'hF;
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        checks++;
        if (wr_if.wr_ready !== 1'b0 || an !== 4'hE || seg !== 7'h40) begin
            errors++;
            $display("FAIL rst_pre rdy=%b an=%h seg=%h want rdy=0 an=e seg=40", wr_if.wr_ready, an, seg);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || wr_if.wr_ready !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_async an=%h seg=%h rdy=%b fd=%b want an=f seg=7f rdy=1 fd=0", an, seg, wr_if.wr_ready, frame_done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'hF || seg !== 7'h7F || wr_if.wr_ready !== 1'b1 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL rst_pend_lost i=%0d an=%h seg=%h rdy=%b fd=%b want an=f seg=7f rdy=1 fd=0",
                         i, an, seg, wr_if.wr_ready, frame_done);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        wr_if.wr_mask  = '0;
        test_reset();
        test_off_write();
        test_pending();
        test_mask();
        test_commit_zero();
        test_lz();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
